// File: rtl/shot_pkg.sv
// Shared widths, FSM state encodings and trigonometric lookup tables for the
// cue-shot controller.
package shot_pkg;

   localparam int ANGLE_W = 5;
   localparam int POWER_W = 6;
   localparam int SPEED_W = 11;
   localparam int STATE_W = 3;

   typedef logic [STATE_W-1:0] state_t;

   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_AIM    = 3'd1;
   localparam state_t S_CHARGE = 3'd2;
   localparam state_t S_FIRE   = 3'd3;
   localparam state_t S_ROLL   = 3'd4;
   localparam state_t S_DONE   = 3'd5;

   // round(127 * cos/sin(2*pi*k/32)); index 0 = +X, clockwise with +Y pointing down
   localparam logic signed [7:0] COS_LUT [32] = '{
       8'sd127,  8'sd125,  8'sd117,  8'sd106,  8'sd90,   8'sd71,   8'sd49,   8'sd25,
       8'sd0,   -8'sd25,  -8'sd49,  -8'sd71,  -8'sd90,  -8'sd106, -8'sd117, -8'sd125,
      -8'sd127, -8'sd125, -8'sd117, -8'sd106, -8'sd90,  -8'sd71,  -8'sd49,  -8'sd25,
       8'sd0,    8'sd25,   8'sd49,   8'sd71,   8'sd90,   8'sd106,  8'sd117,  8'sd125
   };

   localparam logic signed [7:0] SIN_LUT [32] = '{
       8'sd0,    8'sd25,   8'sd49,   8'sd71,   8'sd90,   8'sd106,  8'sd117,  8'sd125,
       8'sd127,  8'sd125,  8'sd117,  8'sd106,  8'sd90,   8'sd71,   8'sd49,   8'sd25,
       8'sd0,   -8'sd25,  -8'sd49,  -8'sd71,  -8'sd90,  -8'sd106, -8'sd117, -8'sd125,
      -8'sd127, -8'sd125, -8'sd117, -8'sd106, -8'sd90,  -8'sd71,  -8'sd49,  -8'sd25
   };

endpackage

// File: rtl/roll_settle_detector.sv
// Watches ball motion after a shot and pulses 'settled' on the frame that
// completes SETTLE_FRAMES consecutive still frames, skipping one grace frame.
module roll_settle_detector #(
   parameter int NUM_BALLS     = 4,
   parameter int SETTLE_FRAMES = 4
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic                 clear,
   input  logic                 startOfFrame,
   input  logic [NUM_BALLS-1:0] ballMoving,
   output logic                 settled
);

   localparam int CNT_W = $clog2(SETTLE_FRAMES + 1);

   logic             r_grace;
   logic [CNT_W-1:0] r_count;
   logic             w_frame;
   logic             w_still;

   // The grace frame lets physics raise ballMoving before we trust it.
   assign w_frame = startOfFrame & ~clear & ~r_grace;
   assign w_still = ~|ballMoving;
   assign settled = w_frame & w_still & (r_count == CNT_W'(SETTLE_FRAMES - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_grace <= 1'b1;
         r_count <= '0;
      end else if (clear) begin
         r_grace <= 1'b1;
         r_count <= '0;
      end else if (startOfFrame) begin
         if (r_grace) begin
            r_grace <= 1'b0;
         end else if (!w_still) begin
            r_count <= '0;
         end else if (r_count != CNT_W'(SETTLE_FRAMES)) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/shot_controller.sv
// Player shot controller: aim and charge while the game grants a hit, fire the
// white ball with a LUT-derived velocity, then report when the table is at rest.
module shot_controller
   import shot_pkg::*;
#(
   parameter int NUM_BALLS     = 4,
   parameter int POWER_MAX     = 63,
   parameter int SETTLE_FRAMES = 4
) (
   input  logic                      clk,
   input  logic                      resetN,
   input  logic                      startOfFrame,
   input  logic                      hitEnable,
   input  logic                      aimLeftN,
   input  logic                      aimRightN,
   input  logic                      shootN,
   input  logic [NUM_BALLS-1:0]      ballMoving,
   output logic [ANGLE_W-1:0]        aimAngle,
   output logic [POWER_W-1:0]        power,
   output logic signed [SPEED_W-1:0] shotSpeedX,
   output logic signed [SPEED_W-1:0] shotSpeedY,
   output logic                      whiteBallMove,
   output logic                      endOfRoll
);

   state_t                      r_state;
   state_t                      w_next;
   logic [ANGLE_W-1:0]          r_angle;
   logic [POWER_W-1:0]          r_power;
   logic signed [SPEED_W-1:0]   r_speed_x;
   logic signed [SPEED_W-1:0]   r_speed_y;

   logic                        w_left;
   logic                        w_right;
   logic                        w_shoot;
   logic                        w_settled;
   logic                        w_fire;

   logic signed [7:0]           w_cos;
   logic signed [7:0]           w_sin;
   logic signed [14:0]          w_cos_ext;
   logic signed [14:0]          w_sin_ext;
   logic signed [14:0]          w_pow_ext;
   logic signed [14:0]          w_prod_x;
   logic signed [14:0]          w_prod_y;
   logic                        w_unused_prod;

   assign w_left  = ~aimLeftN;
   assign w_right = ~aimRightN;
   assign w_shoot = ~shootN;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (hitEnable) w_next = S_AIM;
         S_AIM: begin
            if (!hitEnable)   w_next = S_IDLE;
            else if (w_shoot) w_next = S_CHARGE;
         end
         S_CHARGE: begin
            if (!hitEnable)           w_next = S_IDLE;
            else if (!w_shoot)        w_next = (r_power == '0) ? S_AIM : S_FIRE;
         end
         S_FIRE:   w_next = S_ROLL;
         S_ROLL: begin
            if (hitEnable)      w_next = S_AIM;
            else if (w_settled) w_next = S_DONE;
         end
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   assign w_fire = (r_state == S_CHARGE) && (w_next == S_FIRE);

   // Both operands widened to 15-bit signed; |product| <= 127*63 fits in 14 bits.
   assign w_cos     = COS_LUT[r_angle];
   assign w_sin     = SIN_LUT[r_angle];
   assign w_cos_ext = {{7{w_cos[7]}}, w_cos};
   assign w_sin_ext = {{7{w_sin[7]}}, w_sin};
   assign w_pow_ext = {9'd0, r_power};
   assign w_prod_x  = w_cos_ext * w_pow_ext;
   assign w_prod_y  = w_sin_ext * w_pow_ext;
   assign w_unused_prod = ^{w_prod_x[14], w_prod_x[2:0], w_prod_y[14], w_prod_y[2:0]};

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state   <= S_IDLE;
         r_angle   <= '0;
         r_power   <= '0;
         r_speed_x <= '0;
         r_speed_y <= '0;
      end else begin
         r_state <= w_next;

         if (r_state == S_AIM && w_next == S_AIM && startOfFrame) begin
            if (w_left && !w_right)      r_angle <= r_angle - 1'b1;
            else if (w_right && !w_left) r_angle <= r_angle + 1'b1;
         end

         if (r_state == S_IDLE) begin
            r_power <= '0;
         end else if (r_state == S_AIM && w_next == S_CHARGE) begin
            r_power <= '0;
         end else if (r_state == S_CHARGE && w_next == S_CHARGE && startOfFrame &&
                      r_power < POWER_W'(POWER_MAX)) begin
            r_power <= r_power + 1'b1;
         end

         // Bit slice [13:3] is the >>>3 result: two's-complement shift floors toward -inf.
         if (w_fire) begin
            r_speed_x <= w_prod_x[13:3];
            r_speed_y <= w_prod_y[13:3];
         end
      end
   end

   roll_settle_detector #(
      .NUM_BALLS     (NUM_BALLS),
      .SETTLE_FRAMES (SETTLE_FRAMES)
   ) u_settle (
      .clk          (clk),
      .resetN       (resetN),
      .clear        (r_state != S_ROLL),
      .startOfFrame (startOfFrame),
      .ballMoving   (ballMoving),
      .settled      (w_settled)
   );

   assign aimAngle      = r_angle;
   assign power         = r_power;
   assign shotSpeedX    = r_speed_x;
   assign shotSpeedY    = r_speed_y;
   assign whiteBallMove = (r_state == S_FIRE);
   assign endOfRoll     = (r_state == S_DONE);

endmodule

// File: tb/tb_shot_controller.sv
// Directed bench for shot_controller: table-driven aim stepping plus
// hand-written charge, fire, roll-settle, abort and reset sequences.
module tb_shot_controller;

   logic               clk = 1'b0;
   logic               resetN;
   logic               startOfFrame;
   logic               hitEnable;
   logic               aimLeftN;
   logic               aimRightN;
   logic               shootN;
   logic [3:0]         ballMoving;
   logic [4:0]         aimAngle;
   logic [5:0]         power;
   logic signed [10:0] shotSpeedX;
   logic signed [10:0] shotSpeedY;
   logic               whiteBallMove;
   logic               endOfRoll;

   int n_checks = 0;
   int n_errors = 0;
   int wbm_count = 0;
   int eor_count = 0;
   int wbm_base;
   int eor_base;

   typedef struct {
      logic       left;
      logic       right;
      logic       sof;
      logic [4:0] exp_angle;
   } aim_vec_t;

   aim_vec_t aim_vecs [12];

   shot_controller #(
      .NUM_BALLS     (4),
      .POWER_MAX     (63),
      .SETTLE_FRAMES (4)
   ) dut (
      .clk           (clk),
      .resetN        (resetN),
      .startOfFrame  (startOfFrame),
      .hitEnable     (hitEnable),
      .aimLeftN      (aimLeftN),
      .aimRightN     (aimRightN),
      .shootN        (shootN),
      .ballMoving    (ballMoving),
      .aimAngle      (aimAngle),
      .power         (power),
      .shotSpeedX    (shotSpeedX),
      .shotSpeedY    (shotSpeedY),
      .whiteBallMove (whiteBallMove),
      .endOfRoll     (endOfRoll)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled mid-cycle, so a pulse held N cycles counts N.
   always @(negedge clk) begin
      if (whiteBallMove === 1'b1) wbm_count++;
      if (endOfRoll === 1'b1)     eor_count++;
   end

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " aimAngle"},      int'(aimAngle),      0);
      check({tag, " power"},         int'(power),         0);
      check({tag, " shotSpeedX"},    int'(shotSpeedX),    0);
      check({tag, " shotSpeedY"},    int'(shotSpeedY),    0);
      check({tag, " whiteBallMove"}, int'(whiteBallMove), 0);
      check({tag, " endOfRoll"},     int'(endOfRoll),     0);
   endtask

   // Press shoot, charge n frames, release; checks the one-cycle fire pulse and speeds.
   task automatic shoot(input string tag, input int n, input int exp_pow,
                        input int exp_x, input int exp_y);
      shootN = 1'b0;
      tick();
      frames(n);
      check({tag, " power before release"}, int'(power), exp_pow);
      wbm_base = wbm_count;
      shootN = 1'b1;
      tick();
      check({tag, " whiteBallMove"}, int'(whiteBallMove), 1);
      check({tag, " shotSpeedX"},    int'(shotSpeedX),    exp_x);
      check({tag, " shotSpeedY"},    int'(shotSpeedY),    exp_y);
      check({tag, " power held"},    int'(power),         exp_pow);
      hitEnable = 1'b0;
      tick();
      check({tag, " whiteBallMove cleared"}, int'(whiteBallMove), 0);
      check({tag, " whiteBallMove width"},   wbm_count - wbm_base, 1);
   endtask

   initial begin
      aim_vecs[0]  = '{1'b0, 1'b1, 1'b1, 5'd1};
      aim_vecs[1]  = '{1'b0, 1'b1, 1'b0, 5'd1};
      aim_vecs[2]  = '{1'b0, 1'b1, 1'b1, 5'd2};
      aim_vecs[3]  = '{1'b0, 1'b1, 1'b1, 5'd3};
      aim_vecs[4]  = '{1'b1, 1'b1, 1'b1, 5'd3};
      aim_vecs[5]  = '{1'b0, 1'b0, 1'b1, 5'd3};
      aim_vecs[6]  = '{1'b1, 1'b0, 1'b1, 5'd2};
      aim_vecs[7]  = '{1'b1, 1'b0, 1'b1, 5'd1};
      aim_vecs[8]  = '{1'b1, 1'b0, 1'b1, 5'd0};
      aim_vecs[9]  = '{1'b1, 1'b0, 1'b0, 5'd0};
      aim_vecs[10] = '{1'b1, 1'b0, 1'b1, 5'd31};
      aim_vecs[11] = '{1'b1, 1'b0, 1'b1, 5'd30};

      resetN       = 1'b0;
      startOfFrame = 1'b0;
      hitEnable    = 1'b0;
      aimLeftN     = 1'b1;
      aimRightN    = 1'b1;
      shootN       = 1'b1;
      ballMoving   = 4'b0000;
      #1;
      check_all_zero("reset");
      tick();
      tick();
      resetN = 1'b1;
      tick();

      // Aim stepping from angle 0: only startOfFrame cycles move it.
      hitEnable = 1'b1;
      tick();
      for (int i = 0; i < 12; i++) begin
         aimLeftN     = ~aim_vecs[i].left;
         aimRightN    = ~aim_vecs[i].right;
         startOfFrame = aim_vecs[i].sof;
         tick();
         check($sformatf("aim vector %0d", i), int'(aimAngle), int'(aim_vecs[i].exp_angle));
      end
      aimLeftN     = 1'b1;
      aimRightN    = 1'b1;
      startOfFrame = 1'b0;
      tick();

      // Press and release within one frame: power stays 0, no shot, back to aiming.
      wbm_base = wbm_count;
      shootN = 1'b0;
      tick();
      check("zero-power charge power", int'(power), 0);
      shootN = 1'b1;
      tick();
      tick();
      check("zero-power no whiteBallMove", wbm_count - wbm_base, 0);
      aimRightN = 1'b0;
      frames(2);
      aimRightN = 1'b1;
      check("zero-power back to aim", int'(aimAngle), 0);

      // Angle 0, 10 frames; right key held early in the charge must not move the angle.
      aimRightN = 1'b0;
      shootN = 1'b0;
      tick();
      frames(3);
      aimRightN = 1'b1;
      check("angle frozen in charge", int'(aimAngle), 0);
      frames(7);
      check("power 10", int'(power), 10);
      eor_base = eor_count;
      shootN = 1'b1;
      tick();
      check("shot0 whiteBallMove", int'(whiteBallMove), 1);
      check("shot0 shotSpeedX", int'(shotSpeedX), 158);
      check("shot0 shotSpeedY", int'(shotSpeedY), 0);
      hitEnable  = 1'b0;
      ballMoving = 4'b0001;
      tick();
      check("shot0 whiteBallMove one cycle", int'(whiteBallMove), 0);

      // Roll: 5 moving frames (first is grace), then 4 still frames.
      frames(5);
      ballMoving = 4'b0000;
      frames(3);
      check("roll0 no early endOfRoll", eor_count - eor_base, 0);
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      check("roll0 endOfRoll after 4th still", int'(endOfRoll), 1);
      tick();
      check("roll0 endOfRoll one cycle", int'(endOfRoll), 0);
      check("roll0 endOfRoll count", eor_count - eor_base, 1);
      hitEnable = 1'b1;
      tick();
      tick();
      check("idle clears power", int'(power), 0);

      // Angle 8 at full charge: saturates at 63, straight down.
      aimRightN = 1'b0;
      frames(8);
      aimRightN = 1'b1;
      check("angle 8", int'(aimAngle), 8);
      shoot("shot8", 80, 63, 0, 1000);

      // Motion blip on the 2nd still frame restarts the count.
      eor_base = eor_count;
      ballMoving = 4'b0001;
      frame();
      ballMoving = 4'b0000;
      frame();
      ballMoving = 4'b0010;
      frame();
      ballMoving = 4'b0000;
      frames(3);
      check("blip no early endOfRoll", eor_count - eor_base, 0);
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      check("blip endOfRoll", int'(endOfRoll), 1);
      tick();
      check("blip endOfRoll count", eor_count - eor_base, 1);
      hitEnable = 1'b1;
      tick();

      // Angle 16 at power 8, then hitEnable returns mid-roll: abort without endOfRoll.
      aimRightN = 1'b0;
      frames(8);
      aimRightN = 1'b1;
      check("angle 16", int'(aimAngle), 16);
      shoot("shot16", 8, 8, -127, 0);
      eor_base = eor_count;
      frames(2);
      hitEnable = 1'b1;
      tick();
      frames(5);
      check("abort no endOfRoll", eor_count - eor_base, 0);
      aimRightN = 1'b0;
      frame();
      aimRightN = 1'b1;
      check("abort back to aim", int'(aimAngle), 17);

      // Reset asserted mid-charge: outputs clear at once, pending shot discarded.
      shootN = 1'b0;
      tick();
      frames(5);
      check("pre-reset power", int'(power), 5);
      wbm_base = wbm_count;
      resetN = 1'b0;
      #2;
      check_all_zero("mid-charge reset");
      shootN = 1'b1;
      tick();
      tick();
      resetN = 1'b1;
      frames(4);
      check("post-reset no whiteBallMove", wbm_count - wbm_base, 0);
      check("post-reset power", int'(power), 0);
      check("post-reset angle", int'(aimAngle), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/shot_controller.md
# shot_controller

Player-side shot and roll-tracking block for the billiard table. It sits between the keyboard inputs, the ball physics and the game state machine. While the game FSM grants a hit, it lets the player aim and charge a cue shot, then fires the white ball with a velocity vector. It then watches all balls and reports when the table has come to rest. It produces the `whiteBallMove` and `endOfRoll` events that the game FSM consumes, and it consumes that FSM's `hitEnable`.

## Interface
- `NUM_BALLS`, 4: number of balls monitored for motion, white ball included.
- `POWER_MAX`, 63: power saturation value; must be ≤ 63.
- `SETTLE_FRAMES`, 4: consecutive still frames required before end of roll.
- `clk`  in  1  system clock.
- `resetN`  in  1  asynchronous, active-low reset.
- `startOfFrame`  in  1  one-cycle pulse per video frame.
- `hitEnable`  in  1  high while the game FSM accepts a new hit.
- `aimLeftN`, `aimRightN`  in  1 each  active-low aim keys; already synchronous and debounced.
- `shootN`  in  1  active-low shoot key; synchronous and debounced.
- `ballMoving`  in  NUM_BALLS  per-ball flag, 1 = nonzero speed.
- `aimAngle`  out  5  aim direction index, 0..31, clockwise, 0 = +X.
- `power`  out  6  current charge, for display.
- `shotSpeedX`, `shotSpeedY`  out  signed 11  latched launch velocity; +Y is down the screen.
- `whiteBallMove`  out  1  one-cycle pulse when the shot fires.
- `endOfRoll`  out  1  one-cycle pulse when the table is at rest.

## Operation
- States: S_IDLE, S_AIM, S_CHARGE, S_FIRE, S_ROLL, S_DONE.
- Outputs are Moore-decoded: `whiteBallMove` = (state == S_FIRE); `endOfRoll` = (state == S_DONE).
- S_IDLE:
  - `hitEnable` = 1 → S_AIM.
  - `power` cleared.
- S_AIM:
  - On `startOfFrame`:
    - left only: angle −1 mod 32.
    - right only: angle +1 mod 32.
    - both or neither: no change.
  - `shootN` = 0 → S_CHARGE with `power` ← 0. The transition takes priority; no angle update that cycle.
  - `hitEnable` = 0 → S_IDLE.
- S_CHARGE:
  - Angle frozen.
  - On `startOfFrame`: `power` ← min(power + 1, POWER_MAX).
  - `shootN` = 1 with power = 0 → S_AIM; no shot.
  - `shootN` = 1 with power > 0 → S_FIRE.
  - Release in the same cycle as `startOfFrame`: no increment.
  - `hitEnable` = 0 → S_IDLE; no shot.
- Velocity latch, on the S_CHARGE→S_FIRE edge:
  - `shotSpeedX` ← (COS_LUT[angle] × power) >>> 3.
  - `shotSpeedY` ← (SIN_LUT[angle] × power) >>> 3.
  - LUT entries are signed 8-bit round(127·cos/sin(2πk/32)).
  - The product is 14-bit signed; the arithmetic shift truncates toward −∞.
  - Magnitude is ≤ 1000, so the result fits in 11 bits.
- S_FIRE: one cycle → S_ROLL. Still-frame counter cleared.
- S_ROLL:
  - The first `startOfFrame` after entry is a grace frame and is ignored.
  - On each later `startOfFrame`: if `ballMoving` == 0, increment the still counter; otherwise clear it.
  - When the counter reaches SETTLE_FRAMES → S_DONE.
  - `hitEnable` = 1 while in S_ROLL means the game FSM has moved on (white ball pocketed/reinit) → S_AIM with no `endOfRoll`.
- S_DONE: one cycle → S_IDLE.
- `shotSpeedX`/`shotSpeedY` hold until the next fire.
- Reset values: state S_IDLE, `aimAngle` 0, `power` 0, both speeds 0, both pulses 0.

## Timing
- Shoot-key release at cycle N → S_FIRE and `whiteBallMove` = 1 in cycle N+1 only. Speeds are valid from N+1.
- Interaction with the game FSM: it samples `whiteBallMove` in N+1 and drops `hitEnable` from N+2. Therefore S_ROLL never sees a stale `hitEnable` = 1.
- Qualifying `startOfFrame` at cycle M → `endOfRoll` high in M+1 only.
- Aim and power change only on `startOfFrame` cycles, at most one step per frame.
- Reset mid-operation (resetN low):
  - Immediately returns every output to its reset value.
  - Discards any pending shot and any roll in progress.

## Structure
- Package `shot_pkg` holds:
  - the state enum;
  - ANGLE_W = 5, POWER_W = 6, SPEED_W = 11;
  - COS_LUT/SIN_LUT as 32-entry signed 8-bit localparam arrays.
- Sub-module `roll_settle_detector` contains the grace flag, still counter and threshold compare.
  - Inputs: `clk`, `resetN`, `clear`, `startOfFrame`, `ballMoving`.
  - Output: `settled` pulse.
- The top level holds the FSM, aim/power registers and velocity multiply.

## Test plan
- Reset asserted mid-charge → all outputs 0, state idle, no `whiteBallMove`.
- hitEnable = 1, right held 3 frames → aimAngle = 3. Left then held 5 frames → aimAngle = 30.
- Angle 0, shoot held 10 frames, released → single-cycle `whiteBallMove`, power = 10, shotSpeedX = 158, shotSpeedY = 0.
- Angle 8, shoot held 80 frames → power = 63, shotSpeedX = 0, shotSpeedY = 1000. Angle 16 at power 8 → shotSpeedX = −127.
- Shoot pressed and released within one frame (power 0) → no `whiteBallMove`, back to S_AIM.
- After fire:
  - ballMoving = 4'b0001 for 5 frames, then 0 → `endOfRoll` exactly one cycle after the 4th still frame.
  - A motion blip on the 2nd still frame restarts the count.
  - hitEnable rising during roll → no `endOfRoll`, returns to aiming.
